// File: rtl/rr_mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_pkg
//   Shared definitions for the round-robin mux arbiter:
//     - state_t      : arbiter FSM encoding (IDLE=0, GRANT=1)
//     - REQ_A..REQ_D : requester index constants (0..3), also the mux selects
//     - NUM_REQ      : number of requesters
//     - BURST_W      : width of the burst counter (covers MAX_BURST up to 255)
//     - idx_to_onehot: 2-bit requester index -> 4-bit one-hot grant
// ---------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ = 4;
  localparam int BURST_W = 8;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/n_bit4x1Multiplexer.sv
// ---------------------------------------------------------------------------
// n_bit4x1Multiplexer
//   Purely combinational n-bit 4:1 multiplexer.
//   Ports:
//     A, B, C, D : input  [n-1:0]  data inputs
//     S          : input  [1:0]    select (00->A, 01->B, 10->C, 11->D)
//     Y          : output [n-1:0]  selected data
// ---------------------------------------------------------------------------
module n_bit4x1Multiplexer
  import rr_mux_arbiter_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] C,
  input  logic [n-1:0] D,
  input  logic [1:0]   S,
  output logic [n-1:0] Y
);

  always_comb begin
    Y = '0;
    case (S)
      REQ_A:   Y = A;
      REQ_B:   Y = B;
      REQ_C:   Y = C;
      REQ_D:   Y = D;
      default: Y = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Four-requester round-robin arbiter that also muxes the owner's data onto
//   a single valid/ready output. A grant is decided in IDLE (one cycle of
//   latency), held for the whole GRANT tenure, and released after a transfer
//   marked last, after MAX_BURST transfers, or when the owner drops its
//   request without transferring. Every release costs one IDLE cycle and
//   moves the round-robin pointer to the requester after the old owner.
//
//   Ports:
//     clk        : input         sole clock, rising edge
//     rst        : input         synchronous active-high reset
//     req        : input  [3:0]  per-requester request (bit0=A .. bit3=D)
//     last       : input  [3:0]  per-requester end-of-burst marker
//     A, B, C, D : input  [n-1:0] requester data
//     out_ready  : input         downstream accepts Y this cycle
//     Y          : output [n-1:0] owner data (zero in IDLE)
//     out_valid  : output        Y holds valid data
//     gnt        : output [3:0]  one-hot grant, zero when no owner
//     S          : output [1:0]  index of the current owner
// ---------------------------------------------------------------------------
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int n         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [3:0]   last,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] C,
  input  logic [n-1:0] D,
  input  logic         out_ready,
  output logic [n-1:0] Y,
  output logic         out_valid,
  output logic [3:0]   gnt,
  output logic [1:0]   S
);

  localparam logic [BURST_W-1:0] MAX_BURST_CNT = BURST_W'(MAX_BURST);

  // -------------------------------------------------------------------------
  // Round-robin search: first set request bit at or above ptr, wrapping 3->0.
  // The 2-bit index arithmetic provides the wrap for free.
  // -------------------------------------------------------------------------
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t             state_reg, state_next;
  logic [1:0]         ptr_reg, ptr_next;
  logic [1:0]         s_reg, s_next;
  logic [3:0]         gnt_reg, gnt_next;
  logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic [BURST_W-1:0] burst_cnt_inc;

  logic [1:0]         winner;
  logic [3:0]         owner_req_vec;
  logic [3:0]         owner_last_vec;
  logic               owner_req;
  logic               owner_last;
  logic               transfer;
  logic               release_now;
  logic [n-1:0]       mux_y;

  assign winner        = rr_pick(req, ptr_reg);
  assign burst_cnt_inc = burst_cnt_reg + BURST_W'(1);

  // The grant register is one-hot on S during GRANT, so masking with it
  // picks req[S] / last[S] without a second decoder; both are zero in IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner_sel
      assign owner_req_vec[gi]  = gnt_reg[gi] & req[gi];
      assign owner_last_vec[gi] = gnt_reg[gi] & last[gi];
    end
  endgenerate

  assign owner_req  = |owner_req_vec;
  assign owner_last = |owner_last_vec;

  n_bit4x1Multiplexer #(
    .n(n)
  ) u_data_mux (
    .A(A),
    .B(B),
    .C(C),
    .D(D),
    .S(s_reg),
    .Y(mux_y)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd0;
      s_reg         <= 2'd0;
      gnt_reg       <= 4'd0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      s_reg         <= s_next;
      gnt_reg       <= gnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    s_next         = s_reg;
    gnt_next       = gnt_reg;
    burst_cnt_next = burst_cnt_reg;
    release_now    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          s_next     = winner;
          gnt_next   = idx_to_onehot(winner);
          state_next = GRANT;
        end
      end

      GRANT: begin
        if (transfer) begin
          if (owner_last || (burst_cnt_inc == MAX_BURST_CNT)) begin
            release_now = 1'b1;
          end else begin
            burst_cnt_next = burst_cnt_inc;
          end
        end else if (!owner_req) begin
          // Owner abandoned its request without completing the burst.
          release_now = 1'b1;
        end

        if (release_now) begin
          state_next     = IDLE;
          ptr_next       = s_reg + 2'd1;
          burst_cnt_next = '0;
          gnt_next       = 4'd0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    transfer  = 1'b0;
    Y         = '0;
    if (state_reg == GRANT) begin
      out_valid = owner_req;
      transfer  = owner_req & out_ready;
      Y         = mux_y;
    end
  end

  assign gnt = gnt_reg;
  assign S   = s_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int N   = 8;
  localparam int MAX = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   last;
  logic [N-1:0] A, B, C, D;
  logic         out_ready;
  logic [N-1:0] Y;
  logic         out_valid;
  logic [3:0]   gnt;
  logic [1:0]   S;

  rr_mux_arbiter #(.n(N), .MAX_BURST(MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .A(A), .B(B), .C(C), .D(D),
    .out_ready(out_ready), .Y(Y), .out_valid(out_valid),
    .gnt(gnt), .S(S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the output, where the search starts, and how
  // many transfers the current owner has made.
  bit m_busy    = 1'b0;
  bit m_s_known = 1'b0;
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_cnt     = 0;

  logic [3:0] obs_gnt;
  logic       obs_xfer;

  typedef struct {
    logic [3:0]   req;
    logic [3:0]   last;
    logic         rdy;
    logic [3:0]   gnt;
    logic [1:0]   s;
    logic         chk_s;
    logic         valid;
    logic [N-1:0] y;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] sel_data(input int i);
    case (i)
      0:       return A;
      1:       return B;
      2:       return C;
      default: return D;
    endcase
  endfunction

  task automatic check_model();
    logic [3:0]   e_gnt;
    logic         e_valid;
    logic [N-1:0] e_y;
    e_gnt   = m_busy ? 4'(1 << m_owner) : 4'd0;
    e_valid = m_busy && req[m_owner];
    e_y     = m_busy ? sel_data(m_owner) : '0;
    chk("model_gnt", gnt, e_gnt);
    chk("model_valid", out_valid, e_valid);
    chk("model_y", Y, e_y);
    if (m_busy || m_s_known) chk("model_s", S, m_owner);
  endtask

  task automatic model_update();
    bit found;
    bit rel;
    rel = 1'b0;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0; m_owner = 0; m_s_known = 1;
    end else if (!m_busy) begin
      if (req != 4'd0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            found   = 1'b1;
          end
        end
        m_busy = 1; m_s_known = 1;
      end
    end else begin
      if (req[m_owner] && out_ready) begin
        m_cnt++;
        if (last[m_owner] || m_cnt == MAX) rel = 1'b1;
      end else if (!req[m_owner]) begin
        rel = 1'b1;
      end
      if (rel) begin
        m_busy = 0; m_ptr = (m_owner + 1) % 4; m_cnt = 0; m_s_known = 0;
      end
    end
  endtask

  // Apply inputs just after an edge, then check at the falling edge.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                       input logic rdy);
    rst = r; req = rq; last = lst; out_ready = rdy;
    #4;
    obs_gnt  = gnt;
    obs_xfer = out_valid && out_ready;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    tick();
  endtask

  initial begin
    int  xf;
    bit  done;

    rst = 1'b1; req = 4'd0; last = 4'd0; out_ready = 1'b0;
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44;
    tick();

    // Reset state
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    chk("rst_gnt", gnt, 4'd0);
    chk("rst_s", S, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_y", Y, 8'd0);
    tick();

    // All requesting, every transfer last: grants rotate with one IDLE bubble.
    vecs[0]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h11};
    vecs[2]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h22};
    vecs[4]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h33};
    vecs[6]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h44};
    vecs[8]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h11};
    vecs[10] = '{4'hF, 4'hF, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].req, vecs[i].last, vecs[i].rdy);
      chk($sformatf("rot%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("rot%0d_valid", i), out_valid, vecs[i].valid);
      chk($sformatf("rot%0d_y", i), Y, vecs[i].y);
      if (vecs[i].chk_s) chk($sformatf("rot%0d_s", i), S, vecs[i].s);
      tick();
    end

    // Single requester, no last: burst ends after MAX transfers, then regrant.
    do_reset();
    xf = 0;
    for (int i = 0; i <= 10; i++) begin
      drive(1'b0, 4'b0001, 4'd0, 1'b1);
      if (i <= 9) xf += int'(obs_xfer);
      if (i == 9) chk("burst_idle_gnt", gnt, 4'd0);
      if (i == 10) chk("burst_regrant_gnt", gnt, 4'b0001);
      tick();
    end
    chk("burst_xfers", xf, MAX);

    // Stall on owner C: outputs hold and no transfer is counted.
    do_reset();
    drive(1'b0, 4'b0100, 4'd0, 1'b1); tick();
    drive(1'b0, 4'b0100, 4'd0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0100, 4'd0, 1'b0);
      chk("stall_y", Y, 8'h33);
      chk("stall_s", S, 2'd2);
      chk("stall_gnt", gnt, 4'b0100);
      tick();
    end
    xf = 0; done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'b0100, 4'd0, 1'b1);
      if (obs_gnt == 4'd0) done = 1'b1;
      if (!done) xf += int'(obs_xfer);
      tick();
    end
    chk("stall_remaining_xfers", xf, MAX - 1);

    // Abandon by owner B: IDLE next, pointer moves to 2.
    do_reset();
    drive(1'b0, 4'b0010, 4'd0, 1'b1); tick();
    drive(1'b0, 4'b0001, 4'd0, 1'b0);
    chk("abandon_valid", out_valid, 1'b0);
    tick();
    drive(1'b0, 4'b0101, 4'd0, 1'b0);
    chk("abandon_idle_gnt", gnt, 4'd0);
    tick();
    drive(1'b0, 4'b0101, 4'd0, 1'b0);
    chk("abandon_ptr2_gnt", gnt, 4'b0100);
    tick();
    drive(1'b0, 4'b0001, 4'd0, 1'b0); tick();
    drive(1'b0, 4'b0001, 4'd0, 1'b0); tick();
    drive(1'b0, 4'b0001, 4'd0, 1'b0);
    chk("abandon_wrap_gnt", gnt, 4'b0001);
    tick();

    // Reset on the 3rd transfer of a D burst.
    do_reset();
    drive(1'b0, 4'b1000, 4'd0, 1'b1); tick();
    drive(1'b0, 4'b1000, 4'd0, 1'b1); tick();
    drive(1'b0, 4'b1000, 4'd0, 1'b1); tick();
    drive(1'b1, 4'b1000, 4'd0, 1'b1);
    chk("rstmid_xfer", obs_xfer, 1'b1);
    tick();
    drive(1'b0, 4'b1000, 4'd0, 1'b1);
    chk("rstmid_gnt", gnt, 4'd0);
    chk("rstmid_s", S, 2'd0);
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_y", Y, 8'd0);
    tick();
    drive(1'b0, 4'b1000, 4'd0, 1'b1);
    chk("rstmid_regrant_gnt", gnt, 4'b1000);
    chk("rstmid_regrant_s", S, 2'd3);
    tick();

    // A and D alternate with 8-bit data.
    do_reset();
    A = 8'hA5; B = 8'h5A; C = 8'hC3; D = 8'h3C;
    drive(1'b0, 4'b1001, 4'b1001, 1'b1); tick();
    drive(1'b0, 4'b1001, 4'b1001, 1'b1);
    chk("ad_first_y", Y, 8'hA5);
    chk("ad_first_s", S, 2'd0);
    tick();
    drive(1'b0, 4'b1001, 4'b1001, 1'b1);
    chk("ad_bubble_y", Y, 8'h00);
    tick();
    drive(1'b0, 4'b1001, 4'b1001, 1'b1);
    chk("ad_second_y", Y, 8'h3C);
    chk("ad_second_s", S, 2'd3);
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      A = N'($urandom); B = N'($urandom); C = N'($urandom); D = N'($urandom);
      drive(($urandom_range(0, 63) == 0),
            4'($urandom_range(0, 15)),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter n, default 4, data width of each requester and of the output.
REQ-002 Parameter MAX_BURST, default 8, range 1..255, maximum transfers per grant.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  4  per-requester request; bit i = requester i (0=A, 1=B, 2=C, 3=D).
REQ-007 last  input  4  per-requester end-of-burst marker, sampled only with a transfer.
REQ-008 A, B, C, D  input  n each  requester data.
REQ-009 out_ready  input  1  downstream accepts Y this cycle.
REQ-010 Y  output  n  selected requester data.
REQ-011 out_valid  output  1  Y holds valid data.
REQ-012 gnt  output  4  one-hot grant; all-zero when no owner.
REQ-013 S  output  2  select index of current owner.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-015 In IDLE with req != 0, the block SHALL choose the first set req bit, searching upward from ptr with wrap 3->0.
REQ-016 It SHALL register the choice into S and gnt and enter GRANT on the next edge.
REQ-017 Arbitration latency SHALL be exactly 1 cycle, from req seen in IDLE to gnt asserted.
REQ-018 In IDLE with req == 0, the block SHALL hold state, with gnt=0 and out_valid=0.
REQ-019 In GRANT, Y SHALL equal the data input selected by S (combinational; 00->A, 01->B, 10->C, 11->D).
REQ-020 In GRANT, out_valid SHALL equal req[S].
REQ-021 In IDLE, Y SHALL be all zeros.
REQ-022 A transfer SHALL occur on a cycle with out_valid && out_ready; burst_cnt SHALL then increment.
REQ-023 Release from GRANT SHALL occur on either of two events: a transfer with last[S]=1, or a transfer that makes burst_cnt reach MAX_BURST.
REQ-024 On release, the next state SHALL be IDLE, ptr SHALL become (S+1) mod 4, and burst_cnt SHALL clear.
REQ-025 If req[S] deasserts in GRANT with no transfer that cycle, the block SHALL release the same way (abandon).
REQ-026 Release costs one IDLE bubble; back-to-back grants SHALL be therefore at least 1 cycle apart.
REQ-027 gnt SHALL stay one-hot and stable for the whole GRANT tenure, independent of other req bits.
REQ-028 When out_valid=1 and out_ready=0, Y, S and gnt SHALL hold; no transfer is counted.
REQ-029 last SHALL be ignored on cycles without a transfer.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, burst_cnt=0, gnt=0, S=0, out_valid=0, Y=0.
REQ-031 Reset mid-GRANT SHALL abort the burst with no further transfer counted; arbitration resumes from ptr=0.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1) and the requester index constants REQ_A..REQ_D = 0..3.
REQ-033 The data path SHALL instantiate the existing n_bit4x1Multiplexer once, driven by S; its output is gated to zero in IDLE.
REQ-034 The round-robin priority search SHALL be a combinational function inside rr_mux_arbiter; there is no other sub-module.

Verification
REQ-035 Reset then req=4'b1111, out_ready=1, last=4'b1111 -> grants cycle in order 0,1,2,3,0, each tenure 1 transfer, with one IDLE cycle between grants.
REQ-036 MAX_BURST=8, req=4'b0001, last=0, out_ready=1 -> exactly 8 transfers, then IDLE; the next grant is again 0 (only requester).
REQ-037 Owner 2 streaming, out_ready=0 for 3 cycles -> Y=C, S=2'b10, gnt=4'b0100 held, burst_cnt unchanged.
REQ-038 Owner 1 granted, req[1] drops with out_ready=0 -> IDLE next cycle, ptr=2; a pending req[0] is granted only if bits 2 and 3 are clear.
REQ-039 rst asserted on the 3rd transfer of a burst from requester 3 -> next cycle all outputs 0; with req=4'b1000 the next grant goes to requester 3 after the 1-cycle latency.
REQ-040 n=8, A=8'hA5, D=8'h3C, req=4'b1001, ptr=0 -> first Y=8'hA5 (S=0), after release Y=8'h3C (S=3).
